// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: load-writeback entry layout, default queue depth and PTW slot states.
package rvh_l1d_pkg;

  localparam int LD_WB_DEPTH     = 4;
  localparam int LD_WB_ROB_TAG_W = 4;
  localparam int LD_WB_PREG_W    = 6;
  localparam int LD_WB_XLEN      = 64;

  typedef struct packed {
    logic [LD_WB_ROB_TAG_W-1:0] rob_tag;
    logic [LD_WB_PREG_W-1:0]    prd;
    logic [LD_WB_XLEN-1:0]      data;
    logic                       from_mlfb;
  } ld_wb_entry_t;

  typedef enum logic {
    PTW_IDLE = 1'b0,
    PTW_HELD = 1'b1
  } ptw_state_e;

endpackage

// File: rtl/rvh_l1d_ld_wb_fifo.sv
// Generic pointer FIFO with wrap-bit pointers and full/empty/count; push is ignored when full.
module rvh_l1d_ld_wb_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign count_o = tail_q - head_q;
  assign rdata_o = mem_q[head_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage needs no reset: entries are only visible once the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rvh_l1d_ld_wb_queue.sv
// Load-writeback queue with single-entry PTW response slot and early LSU stall.
// Optional same-cycle empty-queue bypass enabled by defining RVH_L1D_LD_WB_BYPASS_EN.
module rvh_l1d_ld_wb_queue
  import rvh_l1d_pkg::*;
#(
  parameter int DEPTH          = LD_WB_DEPTH,
  parameter int STALL_MARGIN   = 1,
  parameter int ROB_TAG_WIDTH  = 4,
  parameter int PREG_TAG_WIDTH = 6,
  parameter int XLEN           = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_resp_vld_i,
  input  logic [ROB_TAG_WIDTH-1:0]  ld_resp_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0] ld_resp_prd_i,
  input  logic [XLEN-1:0]           ld_resp_data_i,
  input  logic                      ld_resp_from_mlfb_i,
  input  logic                      ptw_resp_vld_i,
  input  logic                      ptw_resp_id_i,
  input  logic [XLEN-1:0]           ptw_resp_pte_i,
  output logic                      wb_vld_o,
  output logic [ROB_TAG_WIDTH-1:0]  wb_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0] wb_prd_o,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      wb_from_mlfb_o,
  input  logic                      wb_rdy_i,
  output logic                      ptw_vld_o,
  output logic                      ptw_id_o,
  output logic [XLEN-1:0]           ptw_pte_o,
  input  logic                      ptw_rdy_i,
  output logic                      ld_pipe_stall_o,
  output logic                      overflow_o
);

  localparam int           AW       = $clog2(DEPTH);
  localparam int           ENTRY_W  = ROB_TAG_WIDTH + PREG_TAG_WIDTH + XLEN + 1;
  localparam logic [AW:0]  STALL_TH = (AW+1)'(DEPTH - STALL_MARGIN);

  logic [ENTRY_W-1:0] in_entry, head_entry;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]        fifo_count;
  logic               overflow_q, overflow_d;
  ptw_state_e         ptw_state_q;
  logic               ptw_vld_q, ptw_id_q;
  logic [XLEN-1:0]    ptw_pte_q;

  assign in_entry = {ld_resp_rob_tag_i, ld_resp_prd_i, ld_resp_data_i, ld_resp_from_mlfb_i};

`ifdef RVH_L1D_LD_WB_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = fifo_empty & ld_resp_vld_i;
  // A bypassed response taken by the arbiter this cycle must not also be queued.
  assign fifo_push  = ld_resp_vld_i & ~(bypass_hit & wb_rdy_i);
  assign wb_vld_o   = ~fifo_empty | bypass_hit;
  assign {wb_rob_tag_o, wb_prd_o, wb_data_o, wb_from_mlfb_o} = bypass_hit ? in_entry : head_entry;
`else
  assign fifo_push  = ld_resp_vld_i;
  assign wb_vld_o   = ~fifo_empty;
  assign {wb_rob_tag_o, wb_prd_o, wb_data_o, wb_from_mlfb_o} = head_entry;
`endif

  assign fifo_pop = ~fifo_empty & wb_rdy_i;

  rvh_l1d_ld_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ld_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (in_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ld_pipe_stall_o = (fifo_count >= STALL_TH);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptw_state_q <= PTW_IDLE;
      ptw_vld_q   <= 1'b0;
      ptw_id_q    <= 1'b0;
      ptw_pte_q   <= '0;
    end else begin
      case (ptw_state_q)
        PTW_IDLE: begin
          if (ptw_resp_vld_i) begin
            ptw_state_q <= PTW_HELD;
            ptw_vld_q   <= 1'b1;
            ptw_id_q    <= ptw_resp_id_i;
            ptw_pte_q   <= ptw_resp_pte_i;
          end
        end
        PTW_HELD: begin
          if (ptw_rdy_i) begin
            if (ptw_resp_vld_i) begin
              ptw_id_q  <= ptw_resp_id_i;
              ptw_pte_q <= ptw_resp_pte_i;
            end else begin
              ptw_state_q <= PTW_IDLE;
              ptw_vld_q   <= 1'b0;
            end
          end
        end
        default: begin
          ptw_state_q <= PTW_IDLE;
          ptw_vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ptw_vld_o = ptw_vld_q;
  assign ptw_id_o  = ptw_id_q;
  assign ptw_pte_o = ptw_pte_q;

  // Full is taken from registered state, so a same-cycle pop never saves the push.
  assign overflow_d = overflow_q
                    | (ld_resp_vld_i & fifo_full)
                    | ((ptw_state_q == PTW_HELD) & ~ptw_rdy_i & ptw_resp_vld_i);

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rvh_l1d_ld_wb_queue.sv
// Randomized and directed bench for rvh_l1d_ld_wb_queue against a queue-based reference model.
module tb_rvh_l1d_ld_wb_queue;

  localparam int DEPTH = 4;
  localparam int STALL_TH = 3;
`ifdef RVH_L1D_LD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_resp_vld_i;
  logic [3:0]  ld_resp_rob_tag_i;
  logic [5:0]  ld_resp_prd_i;
  logic [63:0] ld_resp_data_i;
  logic        ld_resp_from_mlfb_i;
  logic        ptw_resp_vld_i;
  logic        ptw_resp_id_i;
  logic [63:0] ptw_resp_pte_i;
  logic        wb_vld_o;
  logic [3:0]  wb_rob_tag_o;
  logic [5:0]  wb_prd_o;
  logic [63:0] wb_data_o;
  logic        wb_from_mlfb_o;
  logic        wb_rdy_i;
  logic        ptw_vld_o;
  logic        ptw_id_o;
  logic [63:0] ptw_pte_o;
  logic        ptw_rdy_i;
  logic        ld_pipe_stall_o;
  logic        overflow_o;

  rvh_l1d_ld_wb_queue dut (
    .clk                 (clk),
    .rst                 (rst),
    .ld_resp_vld_i       (ld_resp_vld_i),
    .ld_resp_rob_tag_i   (ld_resp_rob_tag_i),
    .ld_resp_prd_i       (ld_resp_prd_i),
    .ld_resp_data_i      (ld_resp_data_i),
    .ld_resp_from_mlfb_i (ld_resp_from_mlfb_i),
    .ptw_resp_vld_i      (ptw_resp_vld_i),
    .ptw_resp_id_i       (ptw_resp_id_i),
    .ptw_resp_pte_i      (ptw_resp_pte_i),
    .wb_vld_o            (wb_vld_o),
    .wb_rob_tag_o        (wb_rob_tag_o),
    .wb_prd_o            (wb_prd_o),
    .wb_data_o           (wb_data_o),
    .wb_from_mlfb_o      (wb_from_mlfb_o),
    .wb_rdy_i            (wb_rdy_i),
    .ptw_vld_o           (ptw_vld_o),
    .ptw_id_o            (ptw_id_o),
    .ptw_pte_o           (ptw_pte_o),
    .ptw_rdy_i           (ptw_rdy_i),
    .ld_pipe_stall_o     (ld_pipe_stall_o),
    .overflow_o          (overflow_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain queue of {tag, prd, data, mlfb} plus the PTW slot.
  logic [74:0] mq[$];
  bit          m_held;
  logic        m_id;
  logic [63:0] m_pte;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs already set: check outputs, advance model, cross the edge.
  task automatic step();
    bit          exp_vld, byp_now, full, popped;
    logic [74:0] exp_e, in_e;
    #2;
    in_e    = {ld_resp_rob_tag_i, ld_resp_prd_i, ld_resp_data_i, ld_resp_from_mlfb_i};
    byp_now = BYP && (mq.size() == 0) && ld_resp_vld_i;
    exp_vld = (mq.size() != 0) || byp_now;
    exp_e   = (mq.size() != 0) ? mq[0] : in_e;
    chk("wb_vld", 64'(wb_vld_o), 64'(exp_vld));
    if (exp_vld) begin
      chk("wb_rob_tag", 64'(wb_rob_tag_o), 64'(exp_e[74:71]));
      chk("wb_prd", 64'(wb_prd_o), 64'(exp_e[70:65]));
      chk("wb_data", wb_data_o, exp_e[64:1]);
      chk("wb_mlfb", 64'(wb_from_mlfb_o), 64'(exp_e[0]));
    end
    chk("stall", 64'(ld_pipe_stall_o), 64'(mq.size() >= STALL_TH));
    chk("ptw_vld", 64'(ptw_vld_o), 64'(m_held));
    if (m_held) begin
      chk("ptw_id", 64'(ptw_id_o), 64'(m_id));
      chk("ptw_pte", ptw_pte_o, m_pte);
    end
    chk("overflow", 64'(overflow_o), 64'(m_ovf));

    if (rst) begin
      mq.delete();
      m_held = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      full   = (mq.size() == DEPTH);
      popped = 1'b0;
      if (wb_rdy_i && mq.size() != 0) begin
        void'(mq.pop_front());
      end else if (wb_rdy_i && byp_now) begin
        popped = 1'b1;
      end
      if (ld_resp_vld_i) begin
        if (full) m_ovf = 1'b1;
        else if (!popped) mq.push_back(in_e);
      end
      if (ptw_resp_vld_i) begin
        if (!m_held || ptw_rdy_i) begin
          m_held = 1'b1;
          m_id   = ptw_resp_id_i;
          m_pte  = ptw_resp_pte_i;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_held && ptw_rdy_i) begin
        m_held = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst            = 1'b0;
    ld_resp_vld_i  = 1'b0;
    ptw_resp_vld_i = 1'b0;
    wb_rdy_i       = 1'b1;
    ptw_rdy_i      = 1'b1;
  endtask

  task automatic set_ld(input logic [3:0] t, input logic [5:0] p, input logic [63:0] d);
    ld_resp_vld_i       = 1'b1;
    ld_resp_rob_tag_i   = t;
    ld_resp_prd_i       = p;
    ld_resp_data_i      = d;
    ld_resp_from_mlfb_i = t[0];
  endtask

  initial begin
    idle_inputs();
    ld_resp_rob_tag_i = '0; ld_resp_prd_i = '0; ld_resp_data_i = '0; ld_resp_from_mlfb_i = 1'b0;
    ptw_resp_id_i = 1'b0; ptw_resp_pte_i = '0;
    m_held = 1'b0; m_ovf = 1'b0; m_id = 1'b0; m_pte = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    step();

    // Single response with arbiter ready.
    idle_inputs();
    set_ld(4'd3, 6'd17, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    idle_inputs();
    repeat (3) step();

    // Back-to-back fill with arbiter stalled, then a fifth push overflows.
    wb_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ld(4'(i + 8), 6'(i + 40), 64'(i) * 64'h0101_0101_0101_0101);
      step();
    end
    idle_inputs();
    wb_rdy_i = 1'b0;
    repeat (2) step();
    wb_rdy_i = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();

    // Occupancy 2, then sustained push+pop across the pointer wrap.
    idle_inputs();
    wb_rdy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_ld(4'(i), 6'(i), 64'(i + 100));
      step();
    end
    wb_rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ld(4'(i + 2), 6'(i + 2), 64'(i + 200));
      step();
    end
    idle_inputs();
    repeat (3) step();

    // PTW response held under backpressure, then a second response overflows.
    ptw_rdy_i      = 1'b0;
    ptw_resp_vld_i = 1'b1;
    ptw_resp_id_i  = 1'b1;
    ptw_resp_pte_i = 64'h2000_0001;
    step();
    ptw_resp_vld_i = 1'b0;
    repeat (3) step();
    ptw_resp_vld_i = 1'b1;
    ptw_resp_id_i  = 1'b0;
    ptw_resp_pte_i = 64'hDEAD_BEEF;
    step();
    ptw_resp_vld_i = 1'b0;
    step();
    ptw_rdy_i = 1'b1;
    repeat (2) step();

    // Reset with three entries queued, then a single fresh push.
    rst = 1'b1;
    step();
    idle_inputs();
    wb_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ld(4'(i + 5), 6'(i + 5), 64'(i + 300));
      step();
    end
    ld_resp_vld_i = 1'b0;
    rst = 1'b1;
    step();
    idle_inputs();
    set_ld(4'd12, 6'd33, 64'h1234_5678_9ABC_DEF0);
    wb_rdy_i = 1'b0;
    step();
    ld_resp_vld_i = 1'b0;
    repeat (2) step();
    wb_rdy_i = 1'b1;
    repeat (2) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst                 = ($urandom_range(0, 99) == 0);
      ld_resp_vld_i       = ($urandom_range(0, 99) < 60);
      ld_resp_rob_tag_i   = 4'($urandom);
      ld_resp_prd_i       = 6'($urandom);
      ld_resp_data_i      = {$urandom, $urandom};
      ld_resp_from_mlfb_i = 1'($urandom);
      wb_rdy_i            = ($urandom_range(0, 99) < 55);
      ptw_resp_vld_i      = ($urandom_range(0, 99) < 20);
      ptw_resp_id_i       = 1'($urandom);
      ptw_resp_pte_i      = {$urandom, $urandom};
      ptw_rdy_i           = ($urandom_range(0, 99) < 60);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
